// File: rtl/array_job_scheduler.sv
// Round-robin scheduler that shares one systolic array between M requesters,
// sequencing each granted job tile by tile with a per-tile watchdog.
module array_job_scheduler #(
   parameter int M       = 4,
   parameter int TW      = 8,
   parameter int TIMEOUT = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [M-1:0]    req_i,
   input  logic [M*TW-1:0] tiles_i,
   output logic [M-1:0]    gnt_o,
   output logic            busy_o,
   output logic            arr_start_o,
   input  logic            arr_done_i,
   output logic [TW-1:0]   tile_idx_o,
   output logic [M-1:0]    job_done_o,
   output logic            err_o
);

   localparam int PW  = (M > 1) ? $clog2(M) : 1;
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

   state_t          state_q, state_d;
   logic [M-1:0]    gnt_q, gnt_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [TW-1:0]   count_q, count_d;
   logic [TW-1:0]   tile_q, tile_d;
   logic [WDW-1:0]  wd_q, wd_d;
   logic            abort_q, abort_d;

   logic [PW-1:0]   win_c;
   logic [PW-1:0]   idx;
   logic            found;
   logic [TW-1:0]   win_tiles;

   // First requester strictly after the last owner, wrapping around.
   always_comb begin
      win_c = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= M; i++) begin
         idx = PW'((int'(rr_q) + i) % M);
         if (!found && req_i[idx]) begin
            win_c = idx;
            found = 1'b1;
         end
      end
   end

   assign win_tiles = tiles_i[win_c*TW +: TW];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      count_d = count_q;
      tile_d  = tile_q;
      wd_d    = wd_q;
      abort_d = abort_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d   = M'(1) << win_c;
               owner_d = win_c;
               count_d = win_tiles;
               tile_d  = '0;
               state_d = (win_tiles == '0) ? S_RELEASE : S_START;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + WDW'(1);
            // a completing tile beats a simultaneous timeout
            if (arr_done_i) begin
               if (tile_q == count_q - TW'(1)) begin
                  state_d = S_RELEASE;
               end else begin
                  tile_d  = tile_q + TW'(1);
                  state_d = S_START;
               end
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               abort_d = 1'b1;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            gnt_d   = '0;
            rr_d    = owner_q;
            abort_d = 1'b0;
            tile_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         rr_q    <= PW'(M - 1);
         count_q <= '0;
         tile_q  <= '0;
         wd_q    <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         count_q <= count_d;
         tile_q  <= tile_d;
         wd_q    <= wd_d;
         abort_q <= abort_d;
      end
   end

   // Pulses are decoded from registered state only.
   assign gnt_o       = gnt_q;
   assign busy_o      = (state_q != S_IDLE);
   assign arr_start_o = (state_q == S_START);
   assign tile_idx_o  = tile_q;
   assign job_done_o  = (state_q == S_RELEASE) ? gnt_q : '0;
   assign err_o       = (state_q == S_RELEASE) && abort_q;

endmodule
